alu_exec_unit: RTL and testbench

//  Execute-stage ALU. Consumes the 4-bit alu_operation code and Jr flag from ALU control.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_comb_core.sv | 33 +++
 rtl/alu_exec_unit.sv | 147 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StShift,
    StDone
  } alu_state_e;

endpackage

// File: rtl/alu_comb_core.sv
// Combinational single-cycle ALU operations plus illegal-code detection.
// SLL is legal here but is computed by the iterative shifter in the top.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             illegal
);

  logic lt;
  assign lt = $signed(a) < $signed(b);

  always_comb begin
    res     = '0;
    illegal = 1'b0;
    unique case (op)
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_SLT: res = {{(WIDTH-1){1'b0}}, lt};
      ALU_NOR: res = ~(a | b);
      ALU_SLL: res = '0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes and a one-bit-per-cycle SLL.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_operation,
  input  logic               jr,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  input  logic [SHIFT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               jr_taken,
  output logic               illegal_op
);

  alu_state_e         state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic               jr_q, jr_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [SHIFT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               jr_taken_q, jr_taken_d;
  logic               illegal_q, illegal_d;

  logic [WIDTH-1:0]   core_res;
  logic               core_illegal;

  alu_comb_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .res     (core_res),
    .illegal (core_illegal)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    jr_d       = jr_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    zero_d     = zero_q;
    jr_taken_d = jr_taken_q;
    illegal_d  = illegal_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d  = alu_operation;
          jr_d  = jr;
          a_d   = operand_a;
          b_d   = operand_b;
          cnt_d = shamt;
          if (!jr && alu_operation == ALU_SLL && shamt != '0) begin
            state_d = StShift;
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        // jr wins over the op code, so a JR never reports an illegal op
        if (jr_q) begin
          result_d   = a_q;
          jr_taken_d = 1'b1;
          illegal_d  = 1'b0;
        end else if (op_q == ALU_SLL) begin
          result_d   = b_q;
          jr_taken_d = 1'b0;
          illegal_d  = 1'b0;
        end else begin
          result_d   = core_res;
          jr_taken_d = 1'b0;
          illegal_d  = core_illegal;
        end
        zero_d  = (result_d == '0);
        state_d = StDone;
      end
      StShift: begin
        // Counter reaching zero means all shifts are done; load on this edge
        if (cnt_q == '0) begin
          result_d   = b_q;
          zero_d     = (b_q == '0);
          jr_taken_d = 1'b0;
          illegal_d  = 1'b0;
          state_d    = StDone;
        end else begin
          b_d   = b_q << 1;
          cnt_d = cnt_q - SHIFT_W'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= '0;
      jr_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      jr_taken_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      jr_q       <= jr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      jr_taken_q <= jr_taken_d;
      illegal_q  <= illegal_d;
    end
  end

  assign in_ready   = (state_q == StIdle) && !reset;
  assign out_valid  = (state_q == StDone);
  assign result     = result_q;
  assign zero       = zero_q;
  assign jr_taken   = jr_taken_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized bench for alu_exec_unit: latency/result model plus directed literal checks.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_operation = 4'h0;
  logic        jr = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        jr_taken;
  logic        illegal_op;

  alu_exec_unit #(
    .WIDTH   (32),
    .SHIFT_W (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_operation (alu_operation),
    .jr            (jr),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .shamt         (shamt),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero          (zero),
    .jr_taken      (jr_taken),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

  // Reference model: a transaction is pending for a fixed number of edges, then held until taken
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_rem = 0;
  logic [31:0] p_res = '0;
  logic        p_jr = 1'b0;
  logic        p_ill = 1'b0;
  logic [31:0] m_res = '0;
  logic        m_zero = 1'b0;
  logic        m_jr = 1'b0;
  logic        m_ill = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_rem  <= 0;
      m_res  <= '0;
      m_zero <= 1'b0;
      m_jr   <= 1'b0;
      m_ill  <= 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        p_jr   <= 1'b0;
        p_ill  <= 1'b0;
        m_rem  <= 1;
        if (jr) begin
          p_res <= operand_a;
          p_jr  <= 1'b1;
        end else begin
          case (alu_operation)
            4'b0000: p_res <= operand_a & operand_b;
            4'b0001: p_res <= operand_a | operand_b;
            4'b0010: p_res <= operand_a + operand_b;
            4'b0110: p_res <= operand_a - operand_b;
            4'b0111: p_res <= ($signed(operand_a) < $signed(operand_b)) ? 32'd1 : 32'd0;
            4'b1100: p_res <= ~(operand_a | operand_b);
            4'b0011: begin
              p_res <= operand_b << shamt;
              m_rem <= int'(shamt) + 1;
            end
            default: begin
              p_res <= '0;
              p_ill <= 1'b1;
            end
          endcase
        end
      end
    end else if (!m_done) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_done <= 1'b1;
        m_res  <= p_res;
        m_zero <= (p_res == 32'd0);
        m_jr   <= p_jr;
        m_ill  <= p_ill;
      end
    end else if (out_ready) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end
  end

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } note_t;
  note_t notes[$];

  int n_checks = 0;
  int n_pass = 0;

  task automatic note(input string name, input logic [31:0] act, input logic [31:0] exp);
    note_t n;
    n.name = name;
    n.act  = act;
    n.exp  = exp;
    notes.push_back(n);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Single compare process: model vs DUT every cycle, then queued directed checks
  always @(negedge clk) begin
    note_t n;
    chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy && !reset});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_done});
    chk("result", result, m_res);
    chk("zero", {31'd0, zero}, {31'd0, m_zero});
    chk("jr_taken", {31'd0, jr_taken}, {31'd0, m_jr});
    chk("illegal_op", {31'd0, illegal_op}, {31'd0, m_ill});
    while (notes.size() > 0) begin
      n = notes.pop_front();
      chk(n.name, n.act, n.exp);
    end
  end

  task automatic send(input logic [3:0] op, input logic j, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh, input int hold,
                      output int lat, output logic [31:0] res);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    alu_operation = op;
    jr = j;
    operand_a = a;
    operand_b = b;
    shamt = sh;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) note("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) note("result_timeout", 32'd0, 32'd1);
    res = result;
    if (hold > 0) begin
      // Offer a different op while busy; it must be ignored
      in_valid = 1'b1;
      alu_operation = 4'b0010;
      jr = 1'b0;
      operand_a = $urandom;
      operand_b = $urandom;
      repeat (hold) @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] res;
    logic [3:0]  codes[7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011};

    repeat (2) @(posedge clk);
    #1;
    note("rst_result", result, 32'd0);
    note("rst_out_valid", {31'd0, out_valid}, 32'd0);
    note("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    note("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    send(4'b0010, 1'b0, 32'd7, 32'd5, 5'd0, 0, lat, res);
    note("add_res", res, 32'd12);
    note("add_model", m_res, 32'd12);
    note("add_zero", {31'd0, zero}, 32'd0);
    note("add_lat", lat, 32'd1);

    send(4'b0110, 1'b0, 32'd5, 32'd5, 5'd0, 0, lat, res);
    note("sub_res", res, 32'd0);
    note("sub_zero", {31'd0, zero}, 32'd1);

    send(4'b0111, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, 0, lat, res);
    note("slt_res", res, 32'd1);
    note("slt_model", m_res, 32'd1);

    send(4'b1100, 1'b0, 32'h0000_00F0, 32'h0000_000F, 5'd0, 0, lat, res);
    note("nor_res", res, 32'hFFFF_FF00);

    send(4'b0011, 1'b0, 32'd0, 32'd1, 5'd31, 0, lat, res);
    note("sll31_res", res, 32'h8000_0000);
    note("sll31_lat", lat, 32'd32);

    send(4'b0011, 1'b0, 32'd0, 32'h0000_1234, 5'd0, 0, lat, res);
    note("sll0_res", res, 32'h0000_1234);
    note("sll0_lat", lat, 32'd1);

    send(4'b0010, 1'b1, 32'h0040_0020, 32'd5, 5'd0, 0, lat, res);
    note("jr_res", res, 32'h0040_0020);
    note("jr_taken", {31'd0, jr_taken}, 32'd1);

    send(4'b0101, 1'b0, 32'd3, 32'd4, 5'd0, 0, lat, res);
    note("ill_res", res, 32'd0);
    note("ill_flag", {31'd0, illegal_op}, 32'd1);
    note("ill_zero", {31'd0, zero}, 32'd1);

    send(4'b0000, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 5, lat, res);
    note("hold_res", result, 32'h00F0_1200);
    note("hold_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset during a long shift
    @(posedge clk); #1;
    in_valid = 1'b1;
    alu_operation = 4'b0011;
    jr = 1'b0;
    operand_b = 32'd1;
    shamt = 5'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    note("mid_rst_result", result, 32'd0);
    note("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    note("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    note("mid_rst_idle", {31'd0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 7) == 7) ? 4'($urandom) : codes[$urandom_range(0, 6)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 3));
      send(op, ($urandom_range(0, 7) == 0), a, b, 5'($urandom), $urandom_range(0, 3), lat, res);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
